// File: rtl/amdc_inverter_fault_monitor.sv
// Inverter gate-drive fault supervisor: sync/debounce, per-channel fault FSM, PWM gating, irq.
// Optional INV_FAULT_COUNT_EN adds a per-channel 8-bit saturating FAULTED-entry counter (flt_count).

module amdc_ifm_lane #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic       flt_n_in,
  input  logic       rdy_in,
  input  logic       mask,
  input  logic       clr_pulse,
  input  logic       pwm_en_req,
  output logic       pwm_en_out,
  output logic       flt_sticky,
  output logic       rdy_sync,
`ifdef INV_FAULT_COUNT_EN
  output logic [7:0] flt_count,
`endif
  output logic       fault_enter
);
  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {ST_OK, ST_FAULTED, ST_CLEARING} state_e;

  logic          flt_s1_q, flt_s2_q, rdy_s1_q, rdy_s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  state_e        state_q, state_d;
  logic          pwm_q, pwm_d, sticky_q, sticky_d, confirm;

  // Fault synchroniser resets high so reset never looks like an asserted fault.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      flt_s1_q <= 1'b1;
      flt_s2_q <= 1'b1;
      rdy_s1_q <= 1'b0;
      rdy_s2_q <= 1'b0;
      cnt_q    <= '0;
      state_q  <= ST_OK;
      pwm_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      flt_s1_q <= flt_n_in;
      flt_s2_q <= flt_s1_q;
      rdy_s1_q <= rdy_in;
      rdy_s2_q <= rdy_s1_q;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      pwm_q    <= pwm_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    cnt_d = '0;
    if (!flt_s2_q) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    // Confirmation is taken on the edge the counter reaches its limit.
    confirm = (cnt_d == CNT_MAX) && !mask;

    state_d = state_q;
    case (state_q)
      ST_OK:       if (confirm) state_d = ST_FAULTED;
      ST_FAULTED:  if (clr_pulse && flt_s2_q) state_d = ST_CLEARING;
      ST_CLEARING: if (confirm) state_d = ST_FAULTED;
                   else if (!pwm_en_req) state_d = ST_OK;
      default:     state_d = ST_OK;
    endcase

    pwm_d       = (state_d == ST_OK) && pwm_en_req;
    sticky_d    = (state_d != ST_OK);
    fault_enter = (state_d == ST_FAULTED) && (state_q != ST_FAULTED);
  end

  assign pwm_en_out = pwm_q;
  assign flt_sticky = sticky_q;
  assign rdy_sync   = rdy_s2_q;

`ifdef INV_FAULT_COUNT_EN
  logic [7:0] fcnt_q, fcnt_d;
  always_comb begin
    fcnt_d = fcnt_q;
    if (fault_enter && fcnt_q != 8'hFF) fcnt_d = fcnt_q + 8'd1;
  end
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) fcnt_q <= '0;
    else        fcnt_q <= fcnt_d;
  end
  assign flt_count = fcnt_q;
`endif
endmodule

module amdc_inverter_fault_monitor #(
  parameter int N_INV           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic [N_INV-1:0]   flt_n_in,
  input  logic [N_INV-1:0]   rdy_in,
  input  logic [N_INV-1:0]   mask,
  input  logic [N_INV-1:0]   clr_pulse,
  input  logic [N_INV-1:0]   pwm_en_req,
  output logic [N_INV-1:0]   pwm_en_out,
  output logic [N_INV-1:0]   flt_sticky,
  output logic [N_INV-1:0]   rdy_sync,
`ifdef INV_FAULT_COUNT_EN
  output logic [8*N_INV-1:0] flt_count,
`endif
  output logic               irq
);
  logic [N_INV-1:0] enter;
  logic             irq_q, irq_d;

  for (genvar i = 0; i < N_INV; i++) begin : g_lane
    amdc_ifm_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .ACLK        (ACLK),
      .ARESET      (ARESET),
      .flt_n_in    (flt_n_in[i]),
      .rdy_in      (rdy_in[i]),
      .mask        (mask[i]),
      .clr_pulse   (clr_pulse[i]),
      .pwm_en_req  (pwm_en_req[i]),
      .pwm_en_out  (pwm_en_out[i]),
      .flt_sticky  (flt_sticky[i]),
      .rdy_sync    (rdy_sync[i]),
`ifdef INV_FAULT_COUNT_EN
      .flt_count   (flt_count[8*i +: 8]),
`endif
      .fault_enter (enter[i])
    );
  end

  always_comb irq_d = |enter;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign irq = irq_q;
endmodule

// File: tb/tb_amdc_inverter_fault_monitor.sv
// Directed bench for amdc_inverter_fault_monitor: expected outputs queued at drive time, popped at check.
module tb_amdc_inverter_fault_monitor;
  logic       ACLK = 1'b0;
  logic       ARESET;
  logic [7:0] flt_n_in, rdy_in, mask, clr_pulse, pwm_en_req;
  logic [7:0] pwm_en_out, flt_sticky, rdy_sync;
  logic       irq;
`ifdef INV_FAULT_COUNT_EN
  logic [63:0] flt_count;
`endif

  int checks = 0;
  int errors = 0;
  int irq_cnt = 0;
  int irq_base;

  typedef struct {
    string      tag;
    logic [7:0] pwm;
    logic [7:0] sticky;
    logic       irq;
  } exp_t;
  exp_t sb[$];

  amdc_inverter_fault_monitor #(.N_INV(8), .DEBOUNCE_CYCLES(16)) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .flt_n_in   (flt_n_in),
    .rdy_in     (rdy_in),
    .mask       (mask),
    .clr_pulse  (clr_pulse),
    .pwm_en_req (pwm_en_req),
    .pwm_en_out (pwm_en_out),
    .flt_sticky (flt_sticky),
    .rdy_sync   (rdy_sync),
`ifdef INV_FAULT_COUNT_EN
    .flt_count  (flt_count),
`endif
    .irq        (irq)
  );

  always #5 ACLK = ~ACLK;

  // irq pulses are tallied one edge after they appear.
  always @(posedge ACLK) if (irq === 1'b1) irq_cnt <= irq_cnt + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  task automatic push(input string tag, input logic [7:0] p, input logic [7:0] s, input logic q);
    exp_t e;
    e.tag = tag; e.pwm = p; e.sticky = s; e.irq = q;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (pwm_en_out === e.pwm) else begin
      errors++; $error("FAIL %s pwm_en_out got %h exp %h", e.tag, pwm_en_out, e.pwm);
    end
    checks++;
    assert (flt_sticky === e.sticky) else begin
      errors++; $error("FAIL %s flt_sticky got %h exp %h", e.tag, flt_sticky, e.sticky);
    end
    checks++;
    assert (irq === e.irq) else begin
      errors++; $error("FAIL %s irq got %b exp %b", e.tag, irq, e.irq);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++; $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  initial begin
    ARESET = 1'b1; flt_n_in = 8'hFF; rdy_in = 8'h00; mask = 8'h00;
    clr_pulse = 8'h00; pwm_en_req = 8'h00;
    tick(3);
    push("reset", 8'h00, 8'h00, 1'b0); pop_check();
    chk_int("reset_rdy", int'(rdy_sync), 0);

    ARESET = 1'b0; pwm_en_req = 8'hFF; rdy_in = 8'hA5;
    push("pwm_pass", 8'hFF, 8'h00, 1'b0);
    tick(1); pop_check();
    tick(1); chk_int("rdy_sync", int'(rdy_sync), 'hA5);
    irq_base = irq_cnt;

    // 15 low samples: below threshold
    flt_n_in[3] = 1'b0; tick(15); flt_n_in[3] = 1'b1;
    push("db15", 8'hFF, 8'h00, 1'b0);
    tick(5); pop_check();
    chk_int("db15_irq", irq_cnt - irq_base, 0);

    // Held low: confirmed exactly 2+16 edges after pin falls
    flt_n_in[3] = 1'b0;
    push("db_edge17", 8'hFF, 8'h00, 1'b0);
    tick(17); pop_check();
    push("db_fault", 8'hF7, 8'h08, 1'b1);
    tick(1); pop_check();
    push("irq_single", 8'hF7, 8'h08, 1'b0);
    tick(1); pop_check();

    clr_pulse[3] = 1'b1;
    push("clr_while_low", 8'hF7, 8'h08, 1'b0);
    tick(1); clr_pulse = 8'h00; pop_check();

    flt_n_in[3] = 1'b1; tick(3);
    clr_pulse[3] = 1'b1;
    push("clearing", 8'hF7, 8'h08, 1'b0);
    tick(1); clr_pulse = 8'h00; pop_check();
    push("clearing_hold", 8'hF7, 8'h08, 1'b0);
    tick(3); pop_check();
    pwm_en_req = 8'hF7;
    push("clear_ok", 8'hF7, 8'h00, 1'b0);
    tick(1); pop_check();
    pwm_en_req = 8'hFF;
    push("restart", 8'hFF, 8'h00, 1'b0);
    tick(1); pop_check();
    chk_int("ch3_irq_cnt", irq_cnt - irq_base, 1);

    // Masked channel 0
    mask = 8'h01; flt_n_in[0] = 1'b0;
    push("masked", 8'hFF, 8'h00, 1'b0);
    tick(40); pop_check();
    pwm_en_req = 8'hFE;
    push("masked_pwm", 8'hFE, 8'h00, 1'b0);
    tick(1); pop_check();
    pwm_en_req = 8'hFF;
    flt_n_in[0] = 1'b1; tick(4); mask = 8'h00;
    chk_int("masked_irq_cnt", irq_cnt - irq_base, 1);

    // Channels 1 and 5 confirm together, clear on 1 coincident with confirm
    flt_n_in[1] = 1'b0; flt_n_in[5] = 1'b0;
    tick(17); clr_pulse[1] = 1'b1;
    push("dual_fault", 8'hDD, 8'h22, 1'b1);
    tick(1); clr_pulse = 8'h00; pop_check();
    tick(2);
    chk_int("dual_irq_cnt", irq_cnt - irq_base, 2);

    flt_n_in = 8'hFF; pwm_en_req = 8'h00; tick(3);
    clr_pulse = 8'h22; tick(1); clr_pulse = 8'h00;
    push("dual_cleared", 8'h00, 8'h00, 1'b0);
    tick(1); pop_check();

    // Reset while faulted: no irq on release
    pwm_en_req = 8'hFF; flt_n_in[4] = 1'b0; tick(20);
    push("ch4_fault", 8'hEF, 8'h10, 1'b0);
    pop_check();
    irq_base = irq_cnt;
    ARESET = 1'b1;
    push("mid_reset", 8'h00, 8'h00, 1'b0);
    tick(1); pop_check();
    flt_n_in[4] = 1'b1; ARESET = 1'b0;
    push("post_reset", 8'hFF, 8'h00, 1'b0);
    tick(3); pop_check();
    chk_int("post_reset_irq", irq_cnt - irq_base, 0);

`ifdef INV_FAULT_COUNT_EN
    pwm_en_req = 8'hFB;
    for (int k = 0; k < 300; k++) begin
      flt_n_in[2] = 1'b0; tick(19);
      flt_n_in[2] = 1'b1; tick(3);
      clr_pulse[2] = 1'b1; tick(1); clr_pulse = 8'h00; tick(1);
      if (k == 9) chk_int("fcount_10", int'(flt_count[23:16]), 10);
    end
    chk_int("fcount_sat", int'(flt_count[23:16]), 255);
    chk_int("fcount_other", int'(flt_count[31:24]), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/amdc_inverter_fault_monitor.md
# amdc_inverter_fault_monitor

Per-inverter fault supervisor between the amdc_inverters AXI4-Lite register file and the inverter gate-drive pins. Synchronises and debounces the active-low driver fault and ready pins, latches confirmed faults, gates each channel's PWM enable, and presents sticky status plus an interrupt pulse back to the register file. Software clears latched faults through per-channel clear pulses decoded from register writes.

## Interface
- N_INV, 8, number of inverter channels (1..8)
- DEBOUNCE_CYCLES, 16, consecutive synchronised fault-low samples needed to confirm a fault (>=1)

- ACLK  in  1  system clock
- ARESET  in  1  asynchronous, active-high reset
- flt_n_in  in  N_INV  raw driver fault pins, active-low, asynchronous to ACLK
- rdy_in  in  N_INV  raw driver ready pins, active-high, asynchronous
- mask  in  N_INV  register bit; 1 = ignore new faults on that channel
- clr_pulse  in  N_INV  one-cycle clear strobe per channel from register write
- pwm_en_req  in  N_INV  PWM enable requested by software/PWM core
- pwm_en_out  out  N_INV  gated PWM enable to gate drive, registered
- flt_sticky  out  N_INV  1 while channel is FAULTED or CLEARING
- rdy_sync  out  N_INV  synchronised rdy_in
- irq  out  1  one-cycle pulse when any channel enters FAULTED

## Operation
- Sync: flt_n_in and rdy_in each pass a 2-flop synchroniser; all logic uses synchronised values.
- Per-channel debounce counter, width clog2(DEBOUNCE_CYCLES+1): increments while synced fault is low, resets to 0 on any high sample, saturates at DEBOUNCE_CYCLES.
- Per-channel FSM:
  - OK: counter reaching DEBOUNCE_CYCLES with mask=0 -> FAULTED. Masked channels stay OK; counter still runs.
  - FAULTED: clr_pulse=1 and synced fault high -> CLEARING; clr_pulse while fault still low is ignored (stays FAULTED). mask changes do not release FAULTED.
  - CLEARING: waits for pwm_en_req=0, then -> OK (prevents PWM restarting mid-period). Fault re-confirmed here -> FAULTED.
- pwm_en_out[i] = pwm_en_req[i] only in OK, else 0.
- irq: OR over channels of OK/CLEARING->FAULTED transition, registered.

## Timing
- Reset: FSMs OK, counters 0, synchronisers 0 (fault pins treated as asserted-low? no: fault sync flops reset to 1 = no fault), pwm_en_out 0, flt_sticky 0, rdy_sync 0, irq 0.
- Pin-low to FAULTED: 2 sync cycles + DEBOUNCE_CYCLES samples; pwm_en_out falls and flt_sticky/irq rise on the same edge that enters FAULTED (registered outputs updated from next-state).
- Fault confirm and clr_pulse in the same cycle: fault wins, channel stays/enters FAULTED, irq pulses if entering.
- clr_pulse in OK or CLEARING: no effect.
- pwm_en_req toggling in OK passes through with one cycle latency.
- ARESET mid-fault: immediate return to reset values; no irq on release.

## Configuration
- INV_FAULT_COUNT_EN defined: adds output flt_count (8*N_INV bits), per-channel 8-bit saturating count of FAULTED entries, cleared only by ARESET, saturates at 255.
- Undefined: port and counters absent; all other behaviour identical.

## Test plan
- Reset: assert ARESET, all pins idle high -> all outputs 0; release, pwm_en_req=8'hFF -> pwm_en_out=8'hFF one cycle later.
- Channel 3 fault low for 15 cycles then high (DEBOUNCE_CYCLES=16) -> no fault; held 16 cycles -> flt_sticky=8'h08, pwm_en_out[3]=0, single irq pulse at cycle 2+16.
- clr_pulse[3] while pin still low -> stays FAULTED; pin high, clr_pulse[3] with pwm_en_req[3]=1 -> CLEARING, flt_sticky[3]=1; drop pwm_en_req[3] -> OK, flt_sticky=0.
- mask=8'h01, channel 0 fault held 40 cycles -> flt_sticky[0]=0, no irq, pwm_en_out[0] follows request.
- Channels 1 and 5 confirm same cycle, clr_pulse[1] coincident -> flt_sticky=8'h22, one irq pulse.
- With INV_FAULT_COUNT_EN: 300 fault/clear cycles on channel 2 -> flt_count[23:16]=8'hFF.
